// File: rtl/hss_pkg.sv
// Shared definitions for the signal-processing chain: sample and index widths,
// peak-detector FSM state encoding and the peak-event record stored in the FIFO.
package hss_pkg;

    localparam int DATA_W = 16;
    localparam int IDX_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        REFRACT = 2'd2
    } pd_state_t;

    // One detected peak: saturated magnitude and the index of its sample.
    typedef struct packed {
        logic [DATA_W-2:0] amp;
        logic [IDX_W-1:0]  idx;
    } peak_evt_t;

endpackage

// File: rtl/peak_fifo.sv
// Peak-event FIFO. A pop and a push in the same cycle both complete, even
// when the FIFO is full. A push into a full FIFO without a pop is ignored
// here; the parent decides what that means. DEPTH must be a power of two.
module peak_fifo #(
    parameter int W     = 31,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});
    assign head  = mem_r[rd_ptr_r];

    // Accept decisions: a pop frees the slot a simultaneous push needs.
    always_comb begin
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/peak_detector.sv
// Peak detector: registers the saturated magnitude of each filtered sample,
// tracks pulses above a threshold, records the largest magnitude (earliest
// index on ties) when the pulse falls below the exit level, then ignores a
// programmable number of samples. Events are queued in peak_fifo.
// Optional feature: define PEAK_DET_HYST_EN to lower the exit level to
// threshold - HYST (saturating at 0); otherwise the exit level is threshold.
module peak_detector #(
    parameter int DATA_W     = hss_pkg::DATA_W,
    parameter int IDX_W      = hss_pkg::IDX_W,
    parameter int FIFO_DEPTH = 4,
    parameter int HYST       = 64
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] data,
    input  logic        [DATA_W-2:0] threshold,
    input  logic        [IDX_W-1:0]  refractory,
    output logic                     peak_valid,
    input  logic                     peak_ready,
    output logic        [DATA_W-2:0] peak_amp,
    output logic        [IDX_W-1:0]  peak_idx,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    import hss_pkg::*;

    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    // Stage 1: magnitude register
    logic [DATA_W-2:0] abs_s;
    logic [DATA_W-2:0] s1_abs_r;
    logic [IDX_W-1:0]  s1_idx_r;
    logic              s1_valid_r;
    logic [IDX_W-1:0]  idx_r;

    // Tracking FSM
    pd_state_t         state_r;
    logic [DATA_W-2:0] max_r;
    logic [IDX_W-1:0]  max_idx_r;
    logic [IDX_W-1:0]  refr_cnt_r;
    logic [DATA_W-2:0] exit_lvl_s;
    logic              push_r;
    peak_evt_t         evt_r;

    // FIFO side
    peak_evt_t         head_s;
    logic              full_s;
    logic              empty_s;
    logic              pop_s;
    logic              drop_s;

    // Saturated magnitude: the most negative code has no positive twin.
    always_comb begin
        abs_s = {(DATA_W-1){1'b0}};
        if (data == MOST_NEG) begin
            abs_s = {(DATA_W-1){1'b1}};
        end else if (data[DATA_W-1]) begin
            abs_s = (~data[DATA_W-2:0]) + (DATA_W-1)'(1);
        end else begin
            abs_s = data[DATA_W-2:0];
        end
    end

    // Capture magnitude and index of each accepted sample; the index wraps.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_r <= 1'b0;
            s1_abs_r   <= {(DATA_W-1){1'b0}};
            s1_idx_r   <= {IDX_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_abs_r <= abs_s;
                s1_idx_r <= idx_r;
                idx_r    <= idx_r + IDX_W'(1);
            end
        end
    end

`ifdef PEAK_DET_HYST_EN
    localparam logic [DATA_W-2:0] HYST_L = (DATA_W-1)'(HYST);

    // Exit level sits HYST below the threshold, never below zero.
    always_comb begin
        exit_lvl_s = {(DATA_W-1){1'b0}};
        if (threshold >= HYST_L) begin
            exit_lvl_s = threshold - HYST_L;
        end else begin
            exit_lvl_s = {(DATA_W-1){1'b0}};
        end
    end
`else
    // Without hysteresis the pulse ends as soon as it drops below threshold.
    always_comb begin
        exit_lvl_s = threshold;
    end
`endif

    // Pulse tracking FSM; it advances only on stage-1 valid samples and
    // registers one event record per finished pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            max_r      <= {(DATA_W-1){1'b0}};
            max_idx_r  <= {IDX_W{1'b0}};
            refr_cnt_r <= {IDX_W{1'b0}};
            push_r     <= 1'b0;
            evt_r      <= '0;
        end else begin
            push_r <= 1'b0;
            if (s1_valid_r) begin
                case (state_r)
                    IDLE: begin
                        if (s1_abs_r >= threshold) begin
                            state_r   <= TRACK;
                            max_r     <= s1_abs_r;
                            max_idx_r <= s1_idx_r;
                        end
                    end
                    TRACK: begin
                        if (s1_abs_r < exit_lvl_s) begin
                            push_r    <= 1'b1;
                            evt_r.amp <= max_r;
                            evt_r.idx <= max_idx_r;
                            if (refractory == {IDX_W{1'b0}}) begin
                                state_r <= IDLE;
                            end else begin
                                state_r    <= REFRACT;
                                refr_cnt_r <= refractory;
                            end
                        end else if (s1_abs_r > max_r) begin
                            max_r     <= s1_abs_r;
                            max_idx_r <= s1_idx_r;
                        end
                    end
                    REFRACT: begin
                        if (refr_cnt_r <= IDX_W'(1)) begin
                            state_r <= IDLE;
                        end else begin
                            refr_cnt_r <= refr_cnt_r - IDX_W'(1);
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

    assign pop_s  = !empty_s && peak_ready;
    assign drop_s = push_r && full_s && !pop_s;

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf <= 1'b0;
        end else if (drop_s) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    peak_fifo #(
        .W     ($bits(peak_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push_r),
        .push_data (evt_r),
        .pop       (pop_s),
        .full      (full_s),
        .empty     (empty_s),
        .head      (head_s)
    );

    assign peak_valid = !empty_s;
    assign peak_amp   = head_s.amp;
    assign peak_idx   = head_s.idx;

endmodule

// File: tb/tb_peak_detector.sv
// Bench for peak_detector: table of single-sequence vectors, hand-written
// latency/FIFO/reset sequences, and randomized streams checked against a
// pulse-segment reference model.
module tb_peak_detector;

    localparam int HYST = 64;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic [15:0] data;
    logic [14:0] threshold;
    logic [15:0] refractory;
    logic        peak_valid;
    logic        peak_ready;
    logic [14:0] peak_amp;
    logic [15:0] peak_idx;
    logic        ovf;
    logic        ovf_clr;

    int total = 0;
    int bad   = 0;

    int got_amp[$];
    int got_idx[$];
    int exp_amp[$];
    int exp_idx[$];

    typedef struct packed {
        logic [0:7][15:0] s;
        logic [14:0]      thr;
        logic [15:0]      refr;
        logic [1:0]       n;
        logic [14:0]      amp0;
        logic [15:0]      idx0;
        logic [14:0]      amp1;
        logic [15:0]      idx1;
    } vec_t;

    localparam int NVEC = 11;
    vec_t tbl [NVEC];

    peak_detector #(
        .DATA_W     (16),
        .IDX_W      (16),
        .FIFO_DEPTH (4),
        .HYST       (HYST)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .data       (data),
        .threshold  (threshold),
        .refractory (refractory),
        .peak_valid (peak_valid),
        .peak_ready (peak_ready),
        .peak_amp   (peak_amp),
        .peak_idx   (peak_idx),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    always #5 CLK = ~CLK;

    // Record every event the consumer pops (pop happens at the next rising edge).
    always @(negedge CLK) begin
        if (RST === 1'b0 && peak_valid === 1'b1 && peak_ready === 1'b1) begin
            got_amp.push_back(int'(peak_amp));
            got_idx.push_back(int'(peak_idx));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic feed(input logic [15:0] v);
        in_valid = 1'b1;
        data     = v;
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        data     = 16'd0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        RST        = 1'b1;
        in_valid   = 1'b0;
        data       = 16'd0;
        ovf_clr    = 1'b0;
        peak_ready = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        got_amp.delete();
        got_idx.delete();
        exp_amp.delete();
        exp_idx.delete();
    endtask

    task automatic check_events(input string name);
        chk($sformatf("%s count", name), got_amp.size(), exp_amp.size());
        for (int k = 0; k < exp_amp.size() && k < got_amp.size(); k++) begin
            chk($sformatf("%s ev%0d amp", name, k), got_amp[k], exp_amp[k]);
            chk($sformatf("%s ev%0d idx", name, k), got_idx[k], exp_idx[k]);
        end
        got_amp.delete();
        got_idx.delete();
        exp_amp.delete();
        exp_idx.delete();
    endtask

    function automatic int sabs(input int s);
        if (s <= -32768) return 32767;
        return (s < 0) ? -s : s;
    endfunction

    function automatic int exit_level(input int thr);
`ifdef PEAK_DET_HYST_EN
        return (thr > HYST) ? thr - HYST : 0;
`else
        return thr;
`endif
    endfunction

    // Reference: find each segment that starts at a sample >= threshold and
    // ends at the first later sample below the exit level; the event is the
    // earliest argmax of the segment; then skip refr samples.
    function automatic void model(input int samples[$], input int thr, input int refr);
        int n  = samples.size();
        int ex = exit_level(thr);
        int i  = 0;
        while (i < n) begin
            if (sabs(samples[i]) >= thr) begin
                int best = i;
                int j    = i + 1;
                bit done = 1'b0;
                while (j < n && !done) begin
                    if (sabs(samples[j]) < ex) begin
                        done = 1'b1;
                    end else begin
                        if (sabs(samples[j]) > sabs(samples[best])) best = j;
                        j++;
                    end
                end
                if (done) begin
                    exp_amp.push_back(sabs(samples[best]));
                    exp_idx.push_back(best);
                    i = j + 1 + refr;
                end else begin
                    i = n;
                end
            end else begin
                i++;
            end
        end
    endfunction

    initial begin
        int lat_exit;
        RST        = 1'b1;
        in_valid   = 1'b0;
        data       = 16'd0;
        threshold  = 15'd100;
        refractory = 16'd0;
        peak_ready = 1'b1;
        ovf_clr    = 1'b0;

        tbl[0]  = '{s:{16'd0, 16'd50, 16'd120, 16'd300, 16'd200, 16'd90, 16'd0, 16'd0},
                    thr:15'd100, refr:16'd0, n:2'd1, amp0:15'd300, idx0:16'd3, amp1:15'd0, idx1:16'd0};
        tbl[1]  = '{s:{-16'sd150, -16'sd200, -16'sd200, 16'd10, 16'd0, 16'd0, 16'd0, 16'd0},
                    thr:15'd100, refr:16'd0, n:2'd1, amp0:15'd200, idx0:16'd1, amp1:15'd0, idx1:16'd0};
        tbl[2]  = '{s:{16'd99, 16'd99, -16'sd99, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                    thr:15'd100, refr:16'd0, n:2'd0, amp0:15'd0, idx0:16'd0, amp1:15'd0, idx1:16'd0};
        tbl[3]  = '{s:{16'd100, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                    thr:15'd100, refr:16'd0, n:2'd1, amp0:15'd100, idx0:16'd0, amp1:15'd0, idx1:16'd0};
        tbl[4]  = '{s:{16'h8000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                    thr:15'd1000, refr:16'd0, n:2'd1, amp0:15'd32767, idx0:16'd0, amp1:15'd0, idx1:16'd0};
        tbl[5]  = '{s:{16'd32767, -16'sd32767, 16'h8000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                    thr:15'd32767, refr:16'd0, n:2'd1, amp0:15'd32767, idx0:16'd0, amp1:15'd0, idx1:16'd0};
        tbl[6]  = '{s:{16'd200, 16'd0, 16'd150, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                    thr:15'd100, refr:16'd0, n:2'd2, amp0:15'd200, idx0:16'd0, amp1:15'd150, idx1:16'd2};
        tbl[7]  = '{s:{16'd200, 16'd0, 16'd0, 16'd200, 16'd0, 16'd200, 16'd0, 16'd0},
                    thr:15'd100, refr:16'd3, n:2'd2, amp0:15'd200, idx0:16'd0, amp1:15'd200, idx1:16'd5};
        tbl[8]  = '{s:{16'd200, 16'd0, 16'd0, 16'd0, 16'd200, 16'd0, 16'd0, 16'd0},
                    thr:15'd100, refr:16'd3, n:2'd1, amp0:15'd200, idx0:16'd0, amp1:15'd0, idx1:16'd0};
        tbl[9]  = '{s:{16'd200, 16'd0, 16'd150, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                    thr:15'd100, refr:16'd1, n:2'd1, amp0:15'd200, idx0:16'd0, amp1:15'd0, idx1:16'd0};
        tbl[10] = '{s:{16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                    thr:15'd1, refr:16'd0, n:2'd1, amp0:15'd5, idx0:16'd0, amp1:15'd0, idx1:16'd0};
`ifdef PEAK_DET_HYST_EN
        // Exit level saturates at 0, so nothing can end this pulse.
        tbl[10].n = 2'd0;
`endif

        // Reset values
        do_reset();
        chk("reset peak_valid", peak_valid, 1'b0);
        chk("reset peak_amp", peak_amp, 15'd0);
        chk("reset peak_idx", peak_idx, 16'd0);
        chk("reset ovf", ovf, 1'b0);

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            do_reset();
            threshold  = tbl[i].thr;
            refractory = tbl[i].refr;
            for (int k = 0; k < 8; k++) feed(tbl[i].s[k]);
            for (int k = 0; k < 3; k++) feed(16'd0);
            idle(6);
            if (tbl[i].n >= 2'd1) begin
                exp_amp.push_back(int'(tbl[i].amp0));
                exp_idx.push_back(int'(tbl[i].idx0));
            end
            if (tbl[i].n >= 2'd2) begin
                exp_amp.push_back(int'(tbl[i].amp1));
                exp_idx.push_back(int'(tbl[i].idx1));
            end
            check_events($sformatf("vec%0d", i));
        end

        // Latency: peak_valid rises two edges after the exit sample is captured
`ifdef PEAK_DET_HYST_EN
        lat_exit = 20;
`else
        lat_exit = 90;
`endif
        do_reset();
        threshold  = 15'd100;
        refractory = 16'd0;
        feed(16'd0); feed(16'd50); feed(16'd120); feed(16'd300); feed(16'd200);
        feed(16'(lat_exit));
        feed(16'd0);
        chk("latency edge1 peak_valid", peak_valid, 1'b0);
        idle(1);
        chk("latency edge2 peak_valid", peak_valid, 1'b1);
        chk("latency amp", peak_amp, 15'd300);
        chk("latency idx", peak_idx, 16'd3);
        idle(1);
        chk("latency popped", peak_valid, 1'b0);

        // Hysteresis scenario
        do_reset();
        threshold = 15'd100;
        feed(16'd150); feed(16'd80); feed(16'd160); feed(16'd20);
        feed(16'd0); feed(16'd0);
        idle(6);
`ifdef PEAK_DET_HYST_EN
        exp_amp.push_back(160); exp_idx.push_back(2);
`else
        exp_amp.push_back(150); exp_idx.push_back(0);
        exp_amp.push_back(160); exp_idx.push_back(2);
`endif
        check_events("hyst");

        // FIFO overflow, head stability, ovf set/clear priority, full push+pop
        do_reset();
        peak_ready = 1'b0;
        threshold  = 15'd100;
        for (int p = 0; p < 5; p++) begin
            feed(16'(200 + 10 * p));
            feed(16'd0);
        end
        idle(3);
        chk("ovf after 5 pulses", ovf, 1'b1);
        chk("full peak_valid", peak_valid, 1'b1);
        chk("full head amp", peak_amp, 15'd200);
        idle(3);
        chk("held head amp", peak_amp, 15'd200);
        chk("held head idx", peak_idx, 16'd0);
        chk("ovf sticky", ovf, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf cleared", ovf, 1'b0);
        feed(16'd250);
        feed(16'd0);
        idle(1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf set beats clear", ovf, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf cleared again", ovf, 1'b0);
        feed(16'd260);
        feed(16'd0);
        idle(1);
        peak_ready = 1'b1;
        tick();
        peak_ready = 1'b0;
        chk("push+pop when full ovf", ovf, 1'b0);
        chk("push+pop when full head", peak_amp, 15'd210);
        peak_ready = 1'b1;
        idle(8);
        exp_amp.push_back(200); exp_idx.push_back(0);
        exp_amp.push_back(210); exp_idx.push_back(2);
        exp_amp.push_back(220); exp_idx.push_back(4);
        exp_amp.push_back(230); exp_idx.push_back(6);
        exp_amp.push_back(260); exp_idx.push_back(12);
        check_events("fifo");
        chk("fifo drained", peak_valid, 1'b0);

        // Reset mid-TRACK discards the pulse and restarts the index
        do_reset();
        threshold = 15'd100;
        feed(16'd150);
        feed(16'd200);
        idle(1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst-track peak_valid", peak_valid, 1'b0);
        chk("rst-track amp", peak_amp, 15'd0);
        chk("rst-track idx", peak_idx, 16'd0);
        chk("rst-track ovf", ovf, 1'b0);
        feed(16'd0); feed(16'd0); feed(16'd0);
        idle(6);
        check_events("rst-track none");
        feed(16'd300);
        feed(16'd0);
        idle(6);
        exp_amp.push_back(300); exp_idx.push_back(3);
        check_events("rst-track restart");

        // Randomized streams against the reference model
        for (int run = 0; run < 4; run++) begin
            int samples[$];
            int thr;
            int refr;
            thr  = $urandom_range(100, 2000);
            refr = $urandom_range(0, 3);
            for (int k = 0; k < 120; k++) begin
                int mag;
                int s;
                mag = $urandom_range(0, 3 * thr);
                s   = ($urandom_range(0, 1) == 1) ? -mag : mag;
                if ($urandom_range(0, 31) == 0) s = -32768;
                samples.push_back(s);
            end
            for (int k = 0; k < 3; k++) samples.push_back(0);
            do_reset();
            threshold  = 15'(thr);
            refractory = 16'(refr);
            foreach (samples[k]) begin
                feed(16'(samples[k]));
                idle($urandom_range(0, 2));
            end
            idle(8);
            model(samples, thr, refr);
            check_events($sformatf("rand%0d", run));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/peak_detector.md
PEAK_DETECTOR -- requirements
Module: peak_detector

Interface
REQ-001 Parameter DATA_W, 16, sample width (signed two's complement, same format as the low-pass filter output).
REQ-002 Parameter IDX_W, 16, sample-index counter width.
REQ-003 Parameter FIFO_DEPTH, 4, peak-event buffer depth (power of two).
REQ-004 Parameter HYST, 64, hysteresis amount in LSBs (used only when the hysteresis feature is enabled).
REQ-005 Port CLK  input  1  single clock for all logic.
REQ-006 Port RST  input  1  reset, synchronous, active-high.
REQ-007 Port in_valid  input  1  data carries a new filtered sample this cycle.
REQ-008 Port data  input  DATA_W  signed filtered sample from the low-pass stage.
REQ-009 Port threshold  input  DATA_W-1  unsigned detection level on |data|.
REQ-010 Port refractory  input  IDX_W  number of valid samples ignored after each event.
REQ-011 Port peak_valid  output  1  event available at FIFO head.
REQ-012 Port peak_ready  input  1  consumer pops the head when peak_valid and peak_ready are both high.
REQ-013 Port peak_amp  output  DATA_W-1  peak magnitude.
REQ-014 Port peak_idx  output  IDX_W  sample index of the peak.
REQ-015 Port ovf  output  1  sticky flag: an event was dropped.
REQ-016 Port ovf_clr  input  1  clears ovf.

Function
REQ-017 Stage 1 SHALL register |data| on in_valid, saturating -32768 to 32767, plus a valid bit and the current sample index.
REQ-018 The sample index SHALL increment once per accepted sample and wrap from 2^IDX_W-1 to 0.
REQ-019 The FSM SHALL have states IDLE, TRACK and REFRACT, and SHALL act only on stage-1 valid samples.
REQ-020 IDLE->TRACK when abs >= threshold: load max=abs, max_idx=index.
REQ-021 In TRACK, abs > max SHALL update max and max_idx; on equal values the earliest index is kept.
REQ-022 TRACK SHALL exit when abs < exit level: push {max, max_idx}, then go to REFRACT, or to IDLE if refractory==0.
REQ-023 REFRACT SHALL count refractory valid samples, ignoring their values, then return to IDLE.
REQ-024 threshold and refractory changes SHALL take effect on the next sample evaluated.
REQ-025 Latency: peak_valid SHALL rise two CLK edges after the edge that captures the exit sample.
REQ-026 FIFO pop and push in the same cycle SHALL both succeed, including when the FIFO is full.
REQ-027 A push into a full FIFO without a simultaneous pop SHALL drop the event and set ovf; ovf_clr clears it, and a set wins over a simultaneous clear.
REQ-028 peak_amp and peak_idx SHALL be stable while peak_valid is high and no pop occurs.

Reset
REQ-029 RST SHALL force: state IDLE, index 0, stage-1 valid 0, FIFO empty, peak_valid 0, ovf 0, peak_amp 0, peak_idx 0.
REQ-030 RST mid-TRACK or mid-REFRACT SHALL discard the partial event, with no push.

Configuration
REQ-031 Macro PEAK_DET_HYST_EN defined: exit level = threshold - HYST, saturating at 0.
REQ-032 Macro PEAK_DET_HYST_EN undefined: exit level = threshold, and the HYST parameter is unused.

Structure
REQ-033 Shared package hss_pkg SHALL hold DATA_W, IDX_W, the FSM state encoding and the peak-event record type.
REQ-034 The FIFO SHALL be a sub-module named peak_fifo with push/pop/full/empty; the FSM and abs stage stay in peak_detector.

Verification
REQ-035 Scenario: threshold=100, refractory=0, samples 0,50,120,300,200,90,0, peak_ready=1 -> one event amp=300 idx=3, with peak_valid two edges after sample 90 is captured.
REQ-036 Scenario: samples -32768 then 0, threshold=1000 -> amp=32767, idx=0.
REQ-037 Scenario: refractory=3, two pulses with the second starting 2 samples after the exit -> only the first event is reported; a pulse starting 4 samples after the exit is reported.
REQ-038 Scenario: peak_ready=0, 5 pulses, FIFO_DEPTH=4 -> 4 events held in order and ovf=1; pulse ovf_clr -> ovf=0.
REQ-039 Scenario: PEAK_DET_HYST_EN defined, threshold=100, HYST=64, samples 150,80,160,20 -> one event amp=160; undefined build -> two events, amp 150 then 160.
REQ-040 Scenario: assert RST while in TRACK, then feed 0s -> no event, all outputs 0, and index restarts at 0.
